// File: rtl/fsm_dispense_if.sv
// Dispenser port bundle: order pulses and sensor in, actuator drives and status out.
// master drives the order side, slave is the dispenser itself.
interface fsm_dispense_if #(
    parameter int DEPTH = 4
) ();
    logic                   sell_flag;
    logic                   change_flag;
    logic                   item_drop;
    logic                   fault_clr;
    logic                   motor_on;
    logic                   coin_eject;
    logic                   busy;
    logic                   vend_done;
    logic                   fault;
    logic                   overflow;
    logic [$clog2(DEPTH):0] pending;

    modport master (
        output sell_flag, change_flag, item_drop, fault_clr,
        input  motor_on, coin_eject, busy, vend_done, fault,
        input  overflow, pending
    );

    modport slave (
        input  sell_flag, change_flag, item_drop, fault_clr,
        output motor_on, coin_eject, busy, vend_done, fault,
        output overflow, pending
    );
endinterface

// File: rtl/fsm_dispense.sv
// Vend sequencer: queues paid orders, runs motor, ejects change, cools down.
// All actuator/status outputs are registered alongside the state.
module fsm_dispense #(
    parameter int DEPTH         = 4,
    parameter int MOTOR_TIMEOUT = 100,
    parameter int EJECT_CYC     = 8,
    parameter int GAP_CYC       = 4
) (
    input  logic           clk,
    input  logic           rst,
    fsm_dispense_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MOTOR_TIMEOUT + EJECT_CYC + GAP_CYC + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        VEND  = 3'd1,
        EJECT = 3'd2,
        GAP   = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t           state;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             chg;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             pop;
    logic             push;

    assign full = (bus.pending == PW'(DEPTH));
    assign pop  = (state == IDLE) && (bus.pending != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push = bus.sell_flag && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem          <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            bus.pending  <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.change_flag;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (bus.sell_flag && !push)
                bus.overflow <= 1'b1;
            case ({push, pop})
                2'b10:   bus.pending <= bus.pending + PW'(1);
                2'b01:   bus.pending <= bus.pending - PW'(1);
                default: bus.pending <= bus.pending;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            chg            <= 1'b0;
            cnt            <= '0;
            bus.motor_on   <= 1'b0;
            bus.coin_eject <= 1'b0;
            bus.busy       <= 1'b0;
            bus.vend_done  <= 1'b0;
            bus.fault      <= 1'b0;
        end else begin
            bus.vend_done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.motor_on   <= pop;
                    bus.coin_eject <= 1'b0;
                    bus.fault      <= 1'b0;
                    bus.busy       <= pop;
                    if (pop) begin
                        chg   <= mem[rd_ptr];
                        cnt   <= '0;
                        state <= VEND;
                    end
                end
                VEND: begin
                    if (bus.item_drop) begin
                        bus.motor_on <= 1'b0;
                        cnt          <= '0;
                        if (chg) begin
                            bus.coin_eject <= 1'b1;
                            state          <= EJECT;
                        end else begin
                            bus.vend_done <= 1'b1;
                            state         <= GAP;
                        end
                    end else if (cnt == CW'(MOTOR_TIMEOUT - 1)) begin
                        bus.motor_on <= 1'b0;
                        bus.fault    <= 1'b1;
                        state        <= FAULT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                EJECT: begin
                    if (cnt == CW'(EJECT_CYC - 1)) begin
                        bus.coin_eject <= 1'b0;
                        bus.vend_done  <= 1'b1;
                        cnt            <= '0;
                        state          <= GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == CW'(GAP_CYC - 1)) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FAULT: begin
                    if (bus.fault_clr) begin
                        bus.fault <= 1'b0;
                        bus.busy  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    bus.motor_on   <= 1'b0;
                    bus.coin_eject <= 1'b0;
                    bus.busy       <= 1'b0;
                    bus.fault      <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fsm_dispense.sv
// Bench for fsm_dispense: timed vend scenarios with a per-order scoreboard
// checking motor/eject lengths at each vend completion or fault.
module tb_fsm_dispense;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fsm_dispense_if #(.DEPTH(4)) bus ();

    fsm_dispense #(
        .DEPTH(4), .MOTOR_TIMEOUT(100), .EJECT_CYC(8), .GAP_CYC(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int motor;
        bit chg;
        bit tmo;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: accumulate actuator cycles per order, settle against the scoreboard
    int motor_cnt = 0;
    int eject_cnt = 0;
    bit fault_q   = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            motor_cnt = 0;
            eject_cnt = 0;
            fault_q   = 1'b0;
        end else begin
            exp_t e;
            motor_cnt += int'(bus.motor_on);
            eject_cnt += int'(bus.coin_eject);
            chk("mutex", int'(bus.motor_on & bus.coin_eject), 0);
            if (bus.vend_done || (bus.fault && !fault_q)) begin
                chk("sb_nonempty", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_kind", int'(bus.fault), int'(e.tmo));
                    chk("sb_motor", motor_cnt, e.motor);
                    chk("sb_eject", eject_cnt, e.chg ? 8 : 0);
                end
                motor_cnt = 0;
                eject_cnt = 0;
            end
            fault_q = bus.fault;
        end
    end

    // One order; item_drop in the k-th motor cycle
    task automatic vend(input bit c, input int k);
        int n;
        sb.push_back('{k, c, 1'b0});
        bus.sell_flag   = 1'b1;
        bus.change_flag = c;
        cyc();
        bus.sell_flag   = 1'b0;
        bus.change_flag = 1'b0;
        chk("motor_early", int'(bus.motor_on), 0);
        cyc();
        chk("motor_start", int'(bus.motor_on), 1);
        chk("busy_vend", int'(bus.busy), 1);
        for (int i = 1; i < k; i++) cyc();
        chk("motor_at_drop", int'(bus.motor_on), 1);
        bus.item_drop = 1'b1;
        cyc();
        bus.item_drop = 1'b0;
        chk("motor_stop", int'(bus.motor_on), 0);
        if (c) begin
            chk("eject_start", int'(bus.coin_eject), 1);
            n = 0;
            for (int i = 0; i < 8; i++) begin
                n += int'(bus.coin_eject);
                cyc();
            end
            chk("eject_len", n, 8);
        end
        chk("vend_done", int'(bus.vend_done), 1);
        chk("gap_quiet", int'({bus.motor_on, bus.coin_eject}), 0);
        repeat (3) cyc();
        chk("gap_busy", int'(bus.busy), 1);
        chk("gap_done_once", int'(bus.vend_done), 0);
        cyc();
        chk("idle_busy", int'(bus.busy), 0);
    endtask

    initial begin
        int n;
        bus.sell_flag   = 1'b0;
        bus.change_flag = 1'b0;
        bus.item_drop   = 1'b0;
        bus.fault_clr   = 1'b0;
        repeat (3) cyc();
        chk("rst_motor", int'(bus.motor_on), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        rst = 1'b1;
        repeat (10) cyc();

        // Plain vend, then a vend owing change
        vend(1'b0, 9);
        repeat (2) cyc();
        vend(1'b1, 4);

        // change_flag alone is not an order
        bus.change_flag = 1'b1;
        cyc();
        bus.change_flag = 1'b0;
        cyc();
        chk("chg_alone", int'(bus.pending), 0);

        // Burst of five while idle, then a sixth into a full FIFO
        bus.sell_flag = 1'b1;
        repeat (5) cyc();
        bus.sell_flag = 1'b0;
        chk("burst_pending", int'(bus.pending), 4);
        chk("burst_ovf", int'(bus.overflow), 0);
        bus.sell_flag = 1'b1;
        cyc();
        bus.sell_flag = 1'b0;
        chk("full_pending", int'(bus.pending), 4);
        chk("full_ovf", int'(bus.overflow), 1);
        repeat (3) cyc();
        chk("ovf_sticky", int'(bus.overflow), 1);
        rst = 1'b0;
        sb.delete();
        cyc();
        rst = 1'b1;
        cyc();

        // Motor timeout, with a second order held through the fault
        sb.push_back('{100, 1'b0, 1'b1});
        bus.sell_flag = 1'b1;
        cyc();
        n = 0;
        for (int i = 0; i < 200 && !bus.fault; i++) begin
            n += int'(bus.motor_on);
            bus.sell_flag = (i == 20);
            if (i == 20) sb.push_back('{3, 1'b0, 1'b0});
            cyc();
        end
        bus.sell_flag = 1'b0;
        chk("timeout_len", n, 100);
        chk("fault_set", int'(bus.fault), 1);
        chk("fault_motor", int'(bus.motor_on), 0);
        chk("fault_held", int'(bus.pending), 1);
        repeat (5) cyc();
        chk("fault_stays", int'(bus.fault), 1);
        bus.fault_clr = 1'b1;
        cyc();
        bus.fault_clr = 1'b0;
        chk("fault_clr", int'(bus.fault), 0);
        cyc();
        chk("resume_motor", int'(bus.motor_on), 1);
        repeat (2) cyc();
        bus.item_drop = 1'b1;
        cyc();
        bus.item_drop = 1'b0;
        chk("resume_done", int'(bus.vend_done), 1);
        repeat (6) cyc();

        // Drop in the final motor cycle beats the timeout
        vend(1'b0, 100);
        chk("edge_no_fault", int'(bus.fault), 0);

        // Reset during eject with an order queued behind it
        bus.sell_flag   = 1'b1;
        bus.change_flag = 1'b1;
        cyc();
        bus.change_flag = 1'b0;
        cyc();
        bus.sell_flag = 1'b0;
        cyc();
        bus.item_drop = 1'b1;
        cyc();
        bus.item_drop = 1'b0;
        cyc();
        chk("pre_rst_eject", int'(bus.coin_eject), 1);
        chk("pre_rst_pending", int'(bus.pending), 1);
        rst = 1'b0;
        #1;
        chk("rst_eject", int'(bus.coin_eject), 0);
        chk("rst_busy_async", int'(bus.busy), 0);
        chk("rst_pending_async", int'(bus.pending), 0);
        cyc();
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            n += int'(bus.motor_on | bus.coin_eject | bus.busy);
            cyc();
        end
        chk("post_rst_quiet", n, 0);

        chk("sb_drained", int'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
